// File: rtl/deser_pkg.sv
// Shared types and constants for the serial word deserializer.
// Optional feature macro: DESER_PARITY_EN (adds one even-parity bit per frame).
package deser_pkg;

   // Frame collection states.
   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   // Default parallel word width.
   localparam int DESER_WIDTH = 4;

   // Serial bits per frame for a given word width. The parity bit, when
   // present, trails the data bits.
   function automatic int frame_len(input int w);
`ifdef DESER_PARITY_EN
      return w + 1;
`else
      return w;
`endif
   endfunction

   localparam int DESER_FRAME_LEN = frame_len(DESER_WIDTH);

endpackage

// File: rtl/deser_out_buffer.sv
// Single-entry valid/ready holding register for completed words.
// A new word loads when the entry is empty or draining this cycle. Any other
// new word is dropped, and the sticky overrun flag is set.
// Optional feature macro: DESER_PARITY_EN (carries parity_err with the word).
module deser_out_buffer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_word,
`ifdef DESER_PARITY_EN
   input  logic             load_perr,
   output logic             parity_err,
`endif
   input  logic             clr_ovr,
   input  logic             word_ready,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   output logic             overrun
);

   logic accept;

   // The entry can take a word if it is empty or is handed off on this edge.
   assign accept = !word_valid || word_ready;

   // Hold, load or drain the buffered word. A drop takes priority over clr_ovr.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_out   <= '0;
         word_valid <= 1'b0;
         overrun    <= 1'b0;
`ifdef DESER_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         if (load && accept) begin
            word_out   <= load_word;
            word_valid <= 1'b1;
`ifdef DESER_PARITY_EN
            parity_err <= load_perr;
`endif
         end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
         end
         if (load && !accept)
            overrun <= 1'b1;
         else if (clr_ovr)
            overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_word_deserializer.sv
// Rebuilds parallel words from an LSB-first serial stream. Completed words
// are handed to a one-entry valid/ready buffer.
// Optional feature macro: DESER_PARITY_EN (each frame ends with an even-parity
// bit, and a parity_err output is added).
module serial_word_deserializer
   import deser_pkg::*;
#(
   parameter int WIDTH = DESER_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             clr_ovr,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             overrun,
`ifdef DESER_PARITY_EN
   output logic             parity_err,
`endif
   output logic             busy
);

   localparam int FRAME = frame_len(WIDTH);
   localparam int CW    = $clog2(WIDTH + 1);

   state_t           state;
   logic [CW-1:0]    bit_cnt;
   logic [CW-1:0]    cur_cnt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] done_word;
   logic             take;
   logic             last;
   logic             done;
   logic             data_bit;

   // start re-aligns the frame, so the bit sampled with it is always bit 0.
   assign take     = bit_valid && (start || state == COLLECT);
   assign cur_cnt  = start ? '0 : bit_cnt;
   assign last     = (cur_cnt == CW'(FRAME - 1));
   assign done     = take && last;
   // LSB-first bits entering at the MSB land in their original positions
   // after WIDTH shifts.
   assign shifted  = {bit_in, sreg[WIDTH-1:1]};

`ifdef DESER_PARITY_EN
   logic done_perr;
   // The trailing parity bit is checked against the data but not shifted in.
   assign data_bit  = (cur_cnt != CW'(WIDTH));
   assign done_word = sreg;
   assign done_perr = (^sreg) ^ bit_in;
`else
   assign data_bit  = 1'b1;
   assign done_word = shifted;
`endif

   assign busy = (state == COLLECT) && (bit_cnt != '0);

   // Frame FSM, bit counter and shift register. The FSM stays in COLLECT
   // after each word, so frames can run back-to-back.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         sreg    <= '0;
      end else begin
         if (start)
            state <= COLLECT;
         if (take) begin
            if (data_bit)
               sreg <= shifted;
            bit_cnt <= last ? '0 : cur_cnt + 1'b1;
         end else if (start) begin
            bit_cnt <= '0;
         end
      end
   end

   deser_out_buffer #(.WIDTH(WIDTH)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .load       (done),
      .load_word  (done_word),
`ifdef DESER_PARITY_EN
      .load_perr  (done_perr),
      .parity_err (parity_err),
`endif
      .clr_ovr    (clr_ovr),
      .word_ready (word_ready),
      .word_out   (word_out),
      .word_valid (word_valid),
      .overrun    (overrun)
   );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer (WIDTH=4).
module tb_serial_word_deserializer;

`ifdef DESER_PARITY_EN
   localparam int FL = 5;
`else
   localparam int FL = 4;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       clr_ovr = 1'b0;
   logic       word_ready = 1'b0;
   logic [3:0] word_out;
   logic       word_valid;
   logic       overrun;
   logic       busy;
`ifdef DESER_PARITY_EN
   logic       parity_err;
`endif

   int total = 0;
   int bad = 0;

   serial_word_deserializer #(.WIDTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .clr_ovr    (clr_ovr),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .overrun    (overrun),
`ifdef DESER_PARITY_EN
      .parity_err (parity_err),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle of serial input.
   task automatic put(input logic b, input logic v, input logic s);
      bit_in    = b;
      bit_valid = v;
      start     = s;
      step();
      bit_valid = 1'b0;
      start     = 1'b0;
   endtask

   // One full frame (plus correct even parity when enabled). word_ready and
   // clr_ovr are set to lr/lc for the final bit of the frame.
   task automatic send_word(input logic [3:0] w, input logic st, input logic lr, input logic lc);
      logic b;
      for (int i = 0; i < FL; i++) begin
         b = (i < 4) ? w[i] : ^w;
         if (i == FL - 1) begin
            word_ready = lr;
            clr_ovr    = lc;
         end
         put(b, 1'b1, (i == 0) && st);
      end
      clr_ovr = 1'b0;
   endtask

   initial begin
      // Reset state.
      step();
      step();
      reset = 1'b0;
      chk("rst_word", word_out, 4'h0);
      chk("rst_valid", word_valid, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      chk("rst_busy", busy, 1'b0);

      // Basic frame 1101 and its handshake.
      word_ready = 1'b1;
      put(1'b1, 1'b1, 1'b1);
      chk("first_busy", busy, 1'b1);
      chk("first_nvalid", word_valid, 1'b0);
      put(1'b0, 1'b1, 1'b0);
      put(1'b1, 1'b1, 1'b0);
`ifdef DESER_PARITY_EN
      put(1'b1, 1'b1, 1'b0);
      chk("basic_notyet", word_valid, 1'b0);
      put(1'b1, 1'b1, 1'b0);
`else
      put(1'b1, 1'b1, 1'b0);
`endif
      chk("basic_valid", word_valid, 1'b1);
      chk("basic_word", word_out, 4'hD);
      chk("basic_busy", busy, 1'b0);
      step();
      chk("basic_drain", word_valid, 1'b0);

      // Back-to-back frames, no second start.
      send_word(4'hD, 1'b0, 1'b1, 1'b0);
      chk("b2b_w1", word_out, 4'hD);
      chk("b2b_v1", word_valid, 1'b1);
      send_word(4'h6, 1'b0, 1'b1, 1'b0);
      chk("b2b_w2", word_out, 4'h6);
      chk("b2b_v2", word_valid, 1'b1);
      chk("b2b_ovr", overrun, 1'b0);
      step();
      chk("b2b_drain", word_valid, 1'b0);

      // Gapped frame 1001: gaps must not shift or count.
      put(1'b1, 1'b1, 1'b0);
      put(1'b1, 1'b0, 1'b0);
      chk("gap_busy", busy, 1'b1);
      put(1'b0, 1'b1, 1'b0);
      put(1'b1, 1'b0, 1'b0);
      put(1'b0, 1'b1, 1'b0);
      put(1'b1, 1'b0, 1'b0);
      chk("gap_nvalid", word_valid, 1'b0);
      put(1'b1, 1'b1, 1'b0);
`ifdef DESER_PARITY_EN
      put(1'b0, 1'b0, 1'b0);
      put(1'b0, 1'b1, 1'b0);
`endif
      chk("gap_word", word_out, 4'h9);
      chk("gap_valid", word_valid, 1'b1);
      step();

      // Back-pressure: drop, set-over-clear priority, clear.
      word_ready = 1'b0;
      send_word(4'h3, 1'b0, 1'b0, 1'b0);
      chk("bp_w1", word_out, 4'h3);
      chk("bp_ovr0", overrun, 1'b0);
      send_word(4'h5, 1'b0, 1'b0, 1'b0);
      chk("bp_ovr1", overrun, 1'b1);
      chk("bp_hold", word_out, 4'h3);
      send_word(4'hA, 1'b0, 1'b0, 1'b1);
      chk("bp_setwins", overrun, 1'b1);
      clr_ovr = 1'b1;
      step();
      clr_ovr = 1'b0;
      chk("bp_clr", overrun, 1'b0);
      chk("bp_still", word_out, 4'h3);
      chk("bp_vstill", word_valid, 1'b1);
      word_ready = 1'b1;
      step();
      chk("bp_drain", word_valid, 1'b0);

      // Drain-and-refill on the completion edge.
      word_ready = 1'b0;
      send_word(4'h7, 1'b0, 1'b0, 1'b0);
      chk("rf_w1", word_out, 4'h7);
      send_word(4'h8, 1'b0, 1'b1, 1'b0);
      chk("rf_w2", word_out, 4'h8);
      chk("rf_v2", word_valid, 1'b1);
      chk("rf_ovr", overrun, 1'b0);
      step();
      chk("rf_drain", word_valid, 1'b0);

      // start mid-frame discards partial bits.
      word_ready = 1'b0;
      put(1'b1, 1'b1, 1'b0);
      put(1'b0, 1'b1, 1'b0);
      send_word(4'h3, 1'b1, 1'b0, 1'b0);
      chk("rs_word", word_out, 4'h3);
      chk("rs_valid", word_valid, 1'b1);
      chk("rs_ovr", overrun, 1'b0);

      // Reset mid-frame with a buffered word, then IDLE ignores bits.
      put(1'b1, 1'b1, 1'b0);
      put(1'b1, 1'b1, 1'b0);
      chk("mr_busy", busy, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mr_valid", word_valid, 1'b0);
      chk("mr_word", word_out, 4'h0);
      chk("mr_busy0", busy, 1'b0);
      for (int i = 0; i < FL; i++) put(1'b1, 1'b1, 1'b0);
      chk("idle_valid", word_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);

`ifdef DESER_PARITY_EN
      // Parity: 1101 has odd weight, so parity 0 is an error, 1 is not.
      word_ready = 1'b1;
      put(1'b1, 1'b1, 1'b1);
      put(1'b0, 1'b1, 1'b0);
      put(1'b1, 1'b1, 1'b0);
      put(1'b1, 1'b1, 1'b0);
      put(1'b0, 1'b1, 1'b0);
      chk("par_w0", word_out, 4'hD);
      chk("par_err1", parity_err, 1'b1);
      put(1'b1, 1'b1, 1'b0);
      put(1'b0, 1'b1, 1'b0);
      put(1'b1, 1'b1, 1'b0);
      put(1'b1, 1'b1, 1'b0);
      put(1'b1, 1'b1, 1'b0);
      chk("par_w1", word_out, 4'hD);
      chk("par_v1", word_valid, 1'b1);
      chk("par_err0", parity_err, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
